button_counter_ctrl: RTL

Parametrised successor to the lab button-started counter. A raw push-button is synchronised and debounced, and each accepted press controls a start/pause/clear state machine. The counter runs up or down to a programmable limit, then either wraps or saturates, and emits a terminal-count pulse. It supports synchronous parallel load and sits between board I/O (button, switches) and display/LED logic.

---
 rtl/button_counter_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/button_counter_ctrl.sv
// Push-button controlled up/down counter: synchroniser, debouncer, press-edge
// detector, IDLE/RUN/DONE state machine and a wrap-or-saturate counter with load.
module button_counter_ctrl #(
  parameter int WIDTH           = 4,
  parameter int MAX_VAL         = 15,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             running,
  output logic             tc,
  output logic [1:0]       state_dbg
);

  localparam int                DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [WIDTH-1:0]  MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [DW-1:0]     DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d, deb_prev_q;
  logic [DW-1:0]    db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] step_val;
  logic             at_bound;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tc_q       <= 1'b0;
    end else begin
      sync1_q    <= button;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tc_q       <= tc_d;
    end
  end

  // The level flips on the edge where the run of differing samples reaches DEBOUNCE_CYCLES.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    press_d = deb_q & ~deb_prev_q;
  end

  // Only arrival at the boundary saturates; a step that starts on the boundary wraps.
  always_comb begin
    if (!dir) begin
      step_val = (cnt_q == MAX_W) ? '0 : cnt_q + 1'b1;
      at_bound = (step_val == MAX_W);
    end else begin
      step_val = (cnt_q == '0) ? MAX_W : cnt_q - 1'b1;
      at_bound = (step_val == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    if (load) begin
      cnt_d = (load_val > MAX_W) ? MAX_W : load_val;
      if (state_q == S_DONE) state_d = S_IDLE;
    end else begin
      if (state_q == S_RUN) begin
        cnt_d = step_val;
        tc_d  = at_bound;
        if (at_bound && !wrap_en) state_d = S_DONE;
      end
      // A press outranks the saturation transition taken on the same edge.
      if (press_q) begin
        case (state_q)
          S_IDLE:  state_d = S_RUN;
          S_RUN:   state_d = S_IDLE;
          S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = dir ? MAX_W : '0;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign cnt       = cnt_q;
  assign running   = (state_q == S_RUN);
  assign tc        = tc_q;
  assign state_dbg = state_q;

endmodule
